// File: rtl/fetch_pc_register.sv
// rtl/fetch_pc_register.sv - front-end fetch PC register with delay-slot tracking
// Optional misaligned-fetch flag enabled by defining PCR_ALIGN_CHECK_EN.
module fetch_pc_register #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_allowin_i,
  input  logic        BTB_predTaken_i,
  input  logic [1:0]  BTB_predIndex_i,
  input  logic [31:0] BTB_predTarget_i,
  input  logic        EXE_redirect_i,
  input  logic [31:0] EXE_redirectPC_i,
  input  logic        EXE_redirectNeedDS_i,
  input  logic [31:0] EXE_redirectDSPC_i,
  input  logic        CP0_excRedirect_i,
  input  logic [31:0] CP0_excPC_i,
  output logic        PCR_valid_o,
  output logic [31:0] PCR_VAddr_o,
  output logic [31:0] PCR_lastVAddr_o,
  output logic        PCR_needDelaySlot_o,
  output logic        PCR_adelExc_o
);

  typedef enum logic {
    NORMAL     = 1'b0,
    DS_PENDING = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] last_q, last_d;
  logic        fire;
  logic        load;

  function automatic logic [31:0] seq_addr(input logic [31:0] a);
    seq_addr = {a[31:4] + 28'd1, 4'b0000};
  endfunction

  assign fire = valid_q & IF_allowin_i;
  assign load = CP0_excRedirect_i | EXE_redirect_i | fire;

  // Redirects win regardless of fire; in DS_PENDING the BTB is ignored.
  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    last_d  = last_q;
    if (CP0_excRedirect_i) begin
      vaddr_d = CP0_excPC_i;
      state_d = NORMAL;
    end else if (EXE_redirect_i) begin
      vaddr_d = EXE_redirectPC_i;
      if (EXE_redirectNeedDS_i) begin
        last_d  = EXE_redirectDSPC_i;
        state_d = DS_PENDING;
      end else begin
        state_d = NORMAL;
      end
    end else if (fire) begin
      case (state_q)
        NORMAL: begin
          if (BTB_predTaken_i) begin
            vaddr_d = BTB_predTarget_i;
            if (BTB_predIndex_i == 2'd3) begin
              last_d  = seq_addr(vaddr_q);
              state_d = DS_PENDING;
            end
          end else begin
            vaddr_d = seq_addr(vaddr_q);
          end
        end
        DS_PENDING: state_d = NORMAL;
        default:    state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= NORMAL;
      valid_q <= 1'b0;
      vaddr_q <= RESET_PC;
      last_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b1;
      vaddr_q <= vaddr_d;
      last_q  <= last_d;
    end
  end

`ifdef PCR_ALIGN_CHECK_EN
  logic        adel_q;
  logic [31:0] next_fetch;

  assign next_fetch = (state_d == DS_PENDING) ? last_d : vaddr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      adel_q <= 1'b0;
    end else if (load) begin
      adel_q <= |next_fetch[1:0];
    end
  end

  assign PCR_adelExc_o = adel_q;
`else
  logic unused_load;
  assign unused_load   = load;
  assign PCR_adelExc_o = 1'b0;
`endif

  assign PCR_valid_o         = valid_q;
  assign PCR_VAddr_o         = vaddr_q;
  assign PCR_lastVAddr_o     = last_q;
  assign PCR_needDelaySlot_o = (state_q == DS_PENDING);

endmodule

// File: tb/tb_fetch_pc_register.sv
// tb/tb_fetch_pc_register.sv - directed and randomized check of fetch_pc_register against a reference model
module tb_fetch_pc_register;

`ifdef PCR_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        allowin;
  logic        taken;
  logic [1:0]  idx;
  logic [31:0] target;
  logic        exe;
  logic [31:0] exe_pc;
  logic        exe_ds;
  logic [31:0] exe_dspc;
  logic        cp0;
  logic [31:0] cp0_pc;

  logic        valid_o;
  logic [31:0] vaddr_o;
  logic [31:0] last_o;
  logic        ds_o;
  logic        adel_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the group being presented and whether it is a delay-slot-only fetch.
  bit          m_valid;
  logic [31:0] m_vaddr;
  logic [31:0] m_last;
  bit          m_ds;

  fetch_pc_register #(.RESET_PC(RST_PC)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .IF_allowin_i         (allowin),
    .BTB_predTaken_i      (taken),
    .BTB_predIndex_i      (idx),
    .BTB_predTarget_i     (target),
    .EXE_redirect_i       (exe),
    .EXE_redirectPC_i     (exe_pc),
    .EXE_redirectNeedDS_i (exe_ds),
    .EXE_redirectDSPC_i   (exe_dspc),
    .CP0_excRedirect_i    (cp0),
    .CP0_excPC_i          (cp0_pc),
    .PCR_valid_o          (valid_o),
    .PCR_VAddr_o          (vaddr_o),
    .PCR_lastVAddr_o      (last_o),
    .PCR_needDelaySlot_o  (ds_o),
    .PCR_adelExc_o        (adel_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] next_group(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) + 32'd16;
  endfunction

  task automatic model_edge();
    bit adv;
    if (!rst) begin
      m_valid = 1'b0;
      m_vaddr = RST_PC;
      m_last  = 32'd0;
      m_ds    = 1'b0;
    end else begin
      adv     = m_valid && allowin;
      m_valid = 1'b1;
      if (cp0) begin
        m_vaddr = cp0_pc;
        m_ds    = 1'b0;
      end else if (exe) begin
        m_vaddr = exe_pc;
        m_ds    = exe_ds;
        if (exe_ds) m_last = exe_dspc;
      end else if (adv) begin
        if (m_ds) begin
          m_ds = 1'b0;
        end else if (taken) begin
          if (idx == 2'd3) begin
            m_last = next_group(m_vaddr);
            m_ds   = 1'b1;
          end
          m_vaddr = target;
        end else begin
          m_vaddr = next_group(m_vaddr);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Addresses never change without a load, so the alignment flag always tracks the presented fetch address.
  task automatic check_model();
    logic [31:0] fa;
    logic        exp_adel;
    fa       = m_ds ? m_last : m_vaddr;
    exp_adel = ALIGN_EN && m_valid && (fa[1:0] != 2'b00);
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check("vaddr", vaddr_o, m_vaddr);
    check("lastvaddr", last_o, m_last);
    check("needds", {31'd0, ds_o}, {31'd0, m_ds});
    check("adel", {31'd0, adel_o}, {31'd0, exp_adel});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    taken = 1'b0; idx = 2'd0; target = 32'd0;
    exe = 1'b0; exe_pc = 32'd0; exe_ds = 1'b0; exe_dspc = 32'd0;
    cp0 = 1'b0; cp0_pc = 32'd0;
  endtask

  task automatic exe_redirect(input logic [31:0] pc, input logic need_ds, input logic [31:0] dspc);
    exe = 1'b1; exe_pc = pc; exe_ds = need_ds; exe_dspc = dspc;
    tick();
    exe = 1'b0;
  endtask

  initial begin
    rst = 1'b0; allowin = 1'b1;
    idle_inputs();
    m_valid = 1'b0; m_vaddr = RST_PC; m_last = 32'd0; m_ds = 1'b0;
    tick();
    tick();
    check("rst_vaddr", vaddr_o, 32'hBFC0_0000);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_adel", {31'd0, adel_o}, 32'd0);
    rst = 1'b1;

    tick();
    check("seq0", vaddr_o, 32'hBFC0_0000);
    check("seq0_valid", {31'd0, valid_o}, 32'd1);
    tick();
    check("seq1", vaddr_o, 32'hBFC0_0010);
    tick();
    check("seq2", vaddr_o, 32'hBFC0_0020);

    exe_redirect(32'h8000_1000, 1'b0, 32'd0);
    taken = 1'b1; idx = 2'd1; target = 32'h8000_2008;
    tick();
    taken = 1'b0;
    check("in_group_tgt", vaddr_o, 32'h8000_2008);
    check("in_group_ds", {31'd0, ds_o}, 32'd0);

    exe_redirect(32'h8000_1000, 1'b0, 32'd0);
    taken = 1'b1; idx = 2'd3; target = 32'h8000_3004;
    tick();
    taken = 1'b0;
    check("ds_flag", {31'd0, ds_o}, 32'd1);
    check("ds_last", last_o, 32'h8000_1010);
    check("ds_tgt", vaddr_o, 32'h8000_3004);
    allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_vaddr", vaddr_o, 32'h8000_3004);
      check("stall_ds", {31'd0, ds_o}, 32'd1);
    end
    allowin = 1'b1;
    tick();
    check("ds_done", {31'd0, ds_o}, 32'd0);
    check("ds_done_vaddr", vaddr_o, 32'h8000_3004);

    cp0 = 1'b1; cp0_pc = 32'hBFC0_0380;
    exe_redirect(32'h8000_4000, 1'b1, 32'h8000_200C);
    cp0 = 1'b0;
    check("cp0_wins", vaddr_o, 32'hBFC0_0380);
    check("cp0_ds", {31'd0, ds_o}, 32'd0);
    exe_redirect(32'h8000_4000, 1'b1, 32'h8000_200C);
    check("exe_ds_flag", {31'd0, ds_o}, 32'd1);
    check("exe_ds_last", last_o, 32'h8000_200C);
    check("exe_ds_tgt", vaddr_o, 32'h8000_4000);
    tick();

    exe_redirect(32'hFFFF_FFF0, 1'b0, 32'd0);
    tick();
    check("wrap", vaddr_o, 32'h0000_0000);

    exe_redirect(32'h8000_0002, 1'b0, 32'd0);
    check("adel_set", {31'd0, adel_o}, {31'd0, ALIGN_EN});
    tick();
    check("adel_seq", vaddr_o, 32'h8000_0010);
    check("adel_clr", {31'd0, adel_o}, 32'd0);

    // Stalled redirect overwrites the held group; reset mid-DS_PENDING drops the target.
    allowin = 1'b0;
    exe_redirect(32'h8000_5000, 1'b1, 32'h8000_4FFC);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_ds_drop", {31'd0, ds_o}, 32'd0);
    check("rst_ds_vaddr", vaddr_o, RST_PC);
    allowin = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      allowin = ($urandom_range(0, 3) != 0);
      taken   = ($urandom_range(0, 2) == 0);
      idx     = 2'($urandom_range(0, 3));
      target  = $urandom;
      if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
      exe      = ($urandom_range(0, 9) == 0);
      exe_pc   = $urandom;
      exe_ds   = $urandom_range(0, 1) == 1;
      exe_dspc = $urandom;
      if ($urandom_range(0, 1) == 0) exe_dspc[1:0] = 2'b00;
      cp0      = ($urandom_range(0, 19) == 0);
      cp0_pc   = $urandom;
      tick();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_register.md
Name: fetch_pc_register

Overview:
- Front-end PC register. It drives the fetch PC, the delay-slot group address and the delay-slot flag into the IF stage's four-PC expander, which feeds the BTB.
- Each accepted cycle it selects the next fetch group from, in priority order: exception redirect, backend mispredict redirect, BTB taken prediction, sequential.
- When a taken branch sits in the last word of a group, it tracks the pending delay-slot fetch across groups.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address loaded on reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low; sampled on rising clk.
- IF_allowin_i  input  1  IF accepts the current group this cycle.
- BTB_predTaken_i  input  1  BTB predicts a taken branch in the current group.
- BTB_predIndex_i  input  2  word index (0-3) of that branch within the group.
- BTB_predTarget_i  input  32  predicted target.
- EXE_redirect_i  input  1  backend mispredict redirect.
- EXE_redirectPC_i  input  32  correct target.
- EXE_redirectNeedDS_i  input  1  the delay slot of the redirecting branch has not been fetched yet.
- EXE_redirectDSPC_i  input  32  address of that delay slot.
- CP0_excRedirect_i  input  1  exception/eret redirect.
- CP0_excPC_i  input  32  exception/eret destination.
- PCR_valid_o  output  1  current group valid.
- PCR_VAddr_o  output  32  fetch address; when the delay-slot flag is set, holds the branch target to fetch afterwards.
- PCR_lastVAddr_o  output  32  delay-slot group address; meaningful only when PCR_needDelaySlot_o=1.
- PCR_needDelaySlot_o  output  1  current group is a delay-slot-only fetch from PCR_lastVAddr_o.
- PCR_adelExc_o  output  1  fetch address misaligned (optional feature).

Behaviour:
- Reset (rst=0 at a clk edge):
  - PCR_VAddr_o=RESET_PC, PCR_lastVAddr_o=0, PCR_needDelaySlot_o=0, PCR_valid_o=0, PCR_adelExc_o=0, state=NORMAL.
  - The first cycle after reset release gives PCR_valid_o=1 with PCR_VAddr_o=RESET_PC.
  - Reset asserted mid-DS_PENDING discards the pending target.
- Advance condition (fire): PCR_valid_o & IF_allowin_i. Without fire and without a redirect, all outputs hold.
- Definitions:
  - seq(a) = {a[31:4]+28'd1, 4'b0000}; wraps 0xFFFFFFF0 -> 0x00000000 with no flag.
  - "Current group base" = PCR_lastVAddr_o when in DS_PENDING, else PCR_VAddr_o.
- State NORMAL, on fire:
  - BTB_predTaken_i & BTB_predIndex_i<3: VAddr<=BTB_predTarget_i; the delay slot is inside the current group.
  - BTB_predTaken_i & BTB_predIndex_i==3: lastVAddr<=seq(VAddr), VAddr<=BTB_predTarget_i, needDelaySlot<=1, goto DS_PENDING.
  - Otherwise: VAddr<=seq(VAddr).
- State DS_PENDING:
  - Outputs present the delay-slot group.
  - On fire: needDelaySlot<=0, goto NORMAL. VAddr is already the target and is kept.
  - BTB prediction is ignored in this state; the delay-slot group holds only the slot.
- Redirects apply regardless of fire and win over everything else. Both force PCR_valid_o=1 next cycle.
  - CP0_excRedirect_i (highest priority): VAddr<=CP0_excPC_i, needDelaySlot<=0, goto NORMAL.
  - Else EXE_redirect_i with NeedDS=1: lastVAddr<=EXE_redirectDSPC_i, VAddr<=EXE_redirectPC_i, needDelaySlot<=1, goto DS_PENDING.
  - Else EXE_redirect_i with NeedDS=0: VAddr<=EXE_redirectPC_i, needDelaySlot<=0, goto NORMAL.
- Simultaneous CP0 and EXE redirects: CP0 wins; the EXE redirect is dropped.
- Redirect arriving while IF stalls (IF_allowin_i=0): applied immediately; the stalled group is overwritten.
- Latency: redirect or advance is visible on outputs one cycle after the triggering edge. There is no combinational path from inputs to outputs.
- VAddr is stored at full width. Bits [3:2] of a redirect or target are kept; the downstream expander substitutes word indices.

Optional Feature:
- Macro: PCR_ALIGN_CHECK_EN.
- Defined:
  - PCR_adelExc_o is registered and set with each VAddr/lastVAddr load when the fetch address used for the next group has [1:0]!=0. That address is lastVAddr in DS_PENDING, else VAddr.
  - It holds until the next load or reset. Addresses are not modified.
- Undefined: PCR_adelExc_o tied 0; no check logic.

Test Plan:
- Reset release, IF_allowin_i=1, no prediction:
  - PCR_VAddr_o sequence 0xBFC00000, 0xBFC00010, 0xBFC00020; PCR_valid_o=1 from the first post-reset cycle.
- At VAddr=0x80001000: BTB_predTaken_i=1, index=1, target 0x80002008 -> next VAddr=0x80002008, needDelaySlot=0.
- At VAddr=0x80001000: BTB_predTaken_i=1, index=3, target 0x80003004:
  - Next cycle: needDelaySlot=1, lastVAddr=0x80001010, VAddr=0x80003004.
  - Hold IF_allowin_i=0 for 3 cycles -> outputs stable.
  - Then allowin=1 -> needDelaySlot=0, VAddr=0x80003004.
- Same cycle: EXE_redirect_i=1 (PC 0x80004000, NeedDS=1, DSPC 0x8000200C) and CP0_excRedirect_i=1 (0xBFC00380) -> VAddr=0xBFC00380, needDelaySlot=0. Repeat without CP0 -> DS_PENDING, lastVAddr=0x8000200C.
- VAddr=0xFFFFFFF0, sequential fire -> VAddr=0x00000000.
- With PCR_ALIGN_CHECK_EN: EXE redirect to 0x80000002 -> PCR_adelExc_o=1 next cycle; following sequential fire to 0x80000010 -> 0. Without the macro -> always 0.
